// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock-enable pixel divider, h/v counters, sync/display
// decode with an optional tick-advanced delay pipeline, and registered strobe outputs.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned HPOS_WIDTH    = 11,
    parameter int unsigned VPOS_WIDTH    = 10,
    parameter int unsigned H_DISPLAY     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_DISPLAY     = 480,
    parameter int unsigned V_BOTTOM      = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_TOP         = 33,
    parameter bit          HSYNC_POL     = 1'b0,
    parameter bit          VSYNC_POL     = 1'b0,
    parameter int unsigned N_PIPE_STAGES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    output logic                  pix_en_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  display_on_o,
    output logic [HPOS_WIDTH-1:0] hpos_o,
    output logic [VPOS_WIDTH-1:0] vpos_o,
    output logic                  line_start_o,
    output logic                  frame_start_o
);

    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned H_MAX        = H_SYNC_END + H_BACK;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int unsigned V_MAX        = V_SYNC_END + V_TOP;

    localparam longint unsigned HCap = 64'd1 << HPOS_WIDTH;
    localparam longint unsigned VCap = 64'd1 << VPOS_WIDTH;

    if (64'(H_MAX) >= HCap) begin : g_hmax_chk
        $error("H_MAX does not fit in HPOS_WIDTH");
    end
    if (64'(V_MAX) >= VCap) begin : g_vmax_chk
        $error("V_MAX does not fit in VPOS_WIDTH");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
        $error("CLK_DIV out of range 1..16");
    end
    if (N_PIPE_STAGES > 8) begin : g_pipe_chk
        $error("N_PIPE_STAGES out of range 0..8");
    end

    localparam logic [4:0]            DivMax     = 5'(CLK_DIV - 1);
    localparam logic [HPOS_WIDTH-1:0] HMax       = HPOS_WIDTH'(H_MAX);
    localparam logic [HPOS_WIDTH-1:0] HSyncStart = HPOS_WIDTH'(H_SYNC_START);
    localparam logic [HPOS_WIDTH-1:0] HSyncEnd   = HPOS_WIDTH'(H_SYNC_END);
    localparam logic [HPOS_WIDTH-1:0] HDisp      = HPOS_WIDTH'(H_DISPLAY);
    localparam logic [VPOS_WIDTH-1:0] VMax       = VPOS_WIDTH'(V_MAX);
    localparam logic [VPOS_WIDTH-1:0] VSyncStart = VPOS_WIDTH'(V_SYNC_START);
    localparam logic [VPOS_WIDTH-1:0] VSyncEnd   = VPOS_WIDTH'(V_SYNC_END);
    localparam logic [VPOS_WIDTH-1:0] VDisp      = VPOS_WIDTH'(V_DISPLAY);

    logic [4:0]            div_q, div_d;
    logic [HPOS_WIDTH-1:0] hpos_q, hpos_d;
    logic [VPOS_WIDTH-1:0] vpos_q, vpos_d;
    logic                  pix_en_q, pix_en_d;
    logic                  line_start_q, line_start_d;
    logic                  frame_start_q, frame_start_d;
    logic                  tick;
    logic [2:0]            raw_act;   // {display, vsync, hsync}, active-high
    logic [2:0]            out_act;

    assign tick = enable_i && (div_q == DivMax);

    always_comb begin
        div_d         = div_q;
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        pix_en_d      = tick;
        line_start_d  = tick && (hpos_q == HMax);
        frame_start_d = tick && (hpos_q == HMax) && (vpos_q == VMax);
        if (enable_i) begin
            div_d = tick ? 5'd0 : div_q + 5'd1;
        end
        if (tick) begin
            if (hpos_q == HMax) begin
                hpos_d = '0;
                vpos_d = (vpos_q == VMax) ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q         <= '0;
            hpos_q        <= HMax;
            vpos_q        <= VMax;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        raw_act    = '0;
        raw_act[0] = (hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd);
        raw_act[1] = (vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd);
        raw_act[2] = (hpos_q < HDisp) && (vpos_q < VDisp);
    end

    if (N_PIPE_STAGES == 0) begin : g_no_pipe
        assign out_act = raw_act;
    end else begin : g_pipe
        logic [2:0] pipe_q [N_PIPE_STAGES];

        // Stage 0 captures the terms of the position being left, so each stage is one tick.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(N_PIPE_STAGES); i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (tick) begin
                pipe_q[0] <= raw_act;
                for (int i = 1; i < int'(N_PIPE_STAGES); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign out_act = pipe_q[N_PIPE_STAGES-1];
    end

    assign hsync_o       = out_act[0] ^ ~HSYNC_POL;
    assign vsync_o       = out_act[1] ^ ~VSYNC_POL;
    assign display_on_o  = out_act[2];
    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    // Strobes are forced low while the generator is paused.
    assign pix_en_o      = pix_en_q && enable_i;
    assign line_start_o  = line_start_q && enable_i;
    assign frame_start_o = frame_start_q && enable_i;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised enable/reset stimulus against a counting model: position is derived from the
// number of enabled clock edges since reset, sync/display from the position N ticks earlier.
module tb_vga_timing_gen;

    localparam int D    = 3;
    localparam int HD   = 20;
    localparam int HF   = 3;
    localparam int HS   = 4;
    localparam int HB   = 5;
    localparam int VD   = 10;
    localparam int VB   = 2;
    localparam int VS   = 2;
    localparam int VT   = 3;
    localparam int NP   = 2;
    localparam int HTOT = HD + HF + HS + HB;
    localparam int VTOT = VD + VB + VS + VT;
    localparam int HW   = 6;
    localparam int VW   = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          pix_en, hsync, vsync, display_on, line_start, frame_start;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;

    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;
    bit tick_last = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV      (D),
        .HPOS_WIDTH   (HW),
        .VPOS_WIDTH   (VW),
        .H_DISPLAY    (HD),
        .H_FRONT      (HF),
        .H_SYNC       (HS),
        .H_BACK       (HB),
        .V_DISPLAY    (VD),
        .V_BOTTOM     (VB),
        .V_SYNC       (VS),
        .V_TOP        (VT),
        .HSYNC_POL    (1'b1),
        .VSYNC_POL    (1'b0),
        .N_PIPE_STAGES(NP)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .pix_en_o     (pix_en),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .display_on_o (display_on),
        .hpos_o       (hpos),
        .vpos_o       (vpos),
        .line_start_o (line_start),
        .frame_start_o(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Position after t ticks since reset; t == 0 is the reset position (H_MAX, V_MAX).
    function automatic void pos_at(input int t, output int h, output int v);
        int idx;
        if (t == 0) begin
            h = HTOT - 1;
            v = VTOT - 1;
        end else begin
            idx = (t - 1) % (HTOT * VTOT);
            h   = idx % HTOT;
            v   = idx / HTOT;
        end
    endfunction

    task automatic check_all(input string ph);
        int  t, h, v, dh, dv;
        bit  ah, av, ad, p;
        t = edges / D;
        pos_at(t, h, v);
        ah = 1'b0;
        av = 1'b0;
        ad = 1'b0;
        if (t - NP > 0) begin
            pos_at(t - NP, dh, dv);
            ah = (dh >= HD + HF) && (dh <= HD + HF + HS - 1);
            av = (dv >= VD + VB) && (dv <= VD + VB + VS - 1);
            ad = (dh < HD) && (dv < VD);
        end
        p = tick_last && enable && rst_n;
        check({ph, ".hpos"}, 32'(hpos), 32'(h));
        check({ph, ".vpos"}, 32'(vpos), 32'(v));
        check({ph, ".hsync"}, 32'(hsync), 32'(ah));
        check({ph, ".vsync"}, 32'(vsync), 32'(!av));
        check({ph, ".display_on"}, 32'(display_on), 32'(ad));
        check({ph, ".pix_en"}, 32'(pix_en), 32'(p));
        check({ph, ".line_start"}, 32'(line_start), 32'(p && h == 0));
        check({ph, ".frame_start"}, 32'(frame_start), 32'(p && h == 0 && v == 0));
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(posedge clk);
            if (rst_n && enable) begin
                edges++;
                tick_last = (edges % D) == 0;
            end else begin
                tick_last = 1'b0;
            end
            @(negedge clk);
            check_all("run");
            if (n_errors > 20) break;
            if (cyc > 200 && $urandom_range(0, 999) < 2) begin
                // Asynchronous reset between edges must take effect before the next edge.
                #1 rst_n = 1'b0;
                edges     = 0;
                tick_last = 1'b0;
                #1 check_all("arst");
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_all("inrst");
                rst_n  = 1'b1;
                enable = 1'b1;
            end else if (cyc < 2000) begin
                enable = 1'b1;
            end else begin
                enable = ($urandom_range(0, 7) != 0);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
